// File: rtl/tx_queue_sched_pkg.sv
// Shared definitions for the egress scheduler: one-hot FSM encodings and the ptr entry layout
// used by the MAC ptr fifo. Optional feature macro: TX_SCHED_WRR_EN.
package tx_queue_sched_pkg;

    localparam int PTR_W       = 16;
    localparam int PTR_LEN_W   = 12;
    localparam int PTR_LEN_LSB = 0;
    localparam int BYTE_W      = 8;

    typedef enum logic [6:0] {
        ST_IDLE       = 7'b0000001,
        ST_PTR_RD     = 7'b0000010,
        ST_PTR_LAT    = 7'b0000100,
        ST_WAIT_SPACE = 7'b0001000,
        ST_COPY       = 7'b0010000,
        ST_DRAIN      = 7'b0100000,
        ST_PTR_WR     = 7'b1000000
    } sched_state_t;

    function automatic logic [PTR_LEN_W-1:0] ptr_len(input logic [PTR_W-1:0] ptr);
        return ptr[PTR_LEN_LSB +: PTR_LEN_W];
    endfunction

endpackage

// File: rtl/tx_queue_sched_arb.sv
// Queue grant selection: strict priority by default, weighted round robin with per-queue
// frame credits when TX_SCHED_WRR_EN is defined.
module tx_queue_sched_arb
    import tx_queue_sched_pkg::*;
#(
    parameter int NQ       = 4,
    parameter int WEIGHT_W = 4,
    parameter int QW       = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NQ-1:0]          req,
    input  logic                   take,
    input  logic [NQ*WEIGHT_W-1:0] q_weight,
    output logic [QW-1:0]          gnt,
    output logic                   gnt_vld
);

`ifdef TX_SCHED_WRR_EN
    logic [WEIGHT_W-1:0] credit [NQ];
    logic [WEIGHT_W-1:0] wt_eff [NQ];
    logic [NQ-1:0]       elig;
    logic [NQ-1:0]       cand;
    logic                reload;
    logic                found;
    logic [QW-1:0]       rr_start;
    int                  idx;

    // When every requester is out of credit, reload and grant in the same cycle.
    always_comb begin
        elig    = '0;
        cand    = '0;
        reload  = 1'b0;
        found   = 1'b0;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            wt_eff[i] = (q_weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                                 : q_weight[i*WEIGHT_W +: WEIGHT_W];
            elig[i]   = req[i] && (credit[i] != '0);
        end
        reload  = (|req) && !(|elig);
        cand    = reload ? req : elig;
        gnt_vld = |cand;
        for (int k = 0; k < NQ; k++) begin
            idx = (int'(rr_start) + k) % NQ;
            if (!found && cand[idx]) begin
                gnt   = QW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NQ; i++) credit[i] <= wt_eff[i];
            rr_start <= '0;
        end else if (take) begin
            for (int i = 0; i < NQ; i++) begin
                if (reload)
                    credit[i] <= (gnt == QW'(i)) ? wt_eff[i] - WEIGHT_W'(1) : wt_eff[i];
                else if (gnt == QW'(i))
                    credit[i] <= credit[i] - WEIGHT_W'(1);
            end
            rr_start <= QW'((int'(gnt) + 1) % NQ);
        end
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rstn, take, q_weight};

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = NQ-1; i >= 0; i--) begin
            if (req[i]) begin
                gnt     = QW'(i);
                gnt_vld = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/tx_queue_sched.sv
// Egress scheduler: copies one whole frame per grant from a per-port queue into the MAC fifos,
// data first and ptr last. Optional feature macro: TX_SCHED_WRR_EN (weighted round robin).
//
// state       | meaning
// IDLE        | waiting for enable, a non-empty queue and MAC ptr space
// PTR_RD      | read pulse to the granted ptr fifo
// PTR_LAT     | ptr valid: latch it, drop zero-length, check MAC data space
// WAIT_SPACE  | frame larger than MAC free space, hold
// COPY        | one data read per cycle for len cycles
// DRAIN       | last delayed byte written to MAC
// PTR_WR      | ptr entry written to MAC, frame released
module tx_queue_sched
    import tx_queue_sched_pkg::*;
#(
    parameter int NQ       = 4,
    parameter int LEN_W    = PTR_LEN_W,
    parameter int WEIGHT_W = 4,
    parameter int QW       = (NQ > 1) ? $clog2(NQ) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic [NQ-1:0]          q_ptr_empty,
    output logic [NQ-1:0]          q_ptr_rd,
    input  logic [NQ*PTR_W-1:0]    q_ptr_dout,
    output logic [NQ-1:0]          q_data_rd,
    input  logic [NQ*BYTE_W-1:0]   q_data_dout,
    input  logic [NQ*WEIGHT_W-1:0] q_weight,
    input  logic                   mac_ptr_full,
    output logic                   mac_ptr_wr,
    output logic [PTR_W-1:0]       mac_ptr_din,
    input  logic [LEN_W:0]         mac_data_free,
    output logic                   mac_data_wr,
    output logic [BYTE_W-1:0]      mac_data_din,
    output logic                   busy,
    output logic [QW-1:0]          cur_q,
    output logic [15:0]            drop_cnt
);

    sched_state_t      state, state_nxt;
    logic [QW-1:0]     gnt_q;
    logic [QW-1:0]     arb_gnt;
    logic              arb_vld;
    logic              take;
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_in;
    logic [BYTE_W-1:0] byte_in;
    logic [LEN_W-1:0]  len_in;
    logic [LEN_W-1:0]  len_cnt;
    logic              rd_dly;
    logic [15:0]       drop_cnt_q;

    tx_queue_sched_arb #(
        .NQ       (NQ),
        .WEIGHT_W (WEIGHT_W),
        .QW       (QW)
    ) u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .req      (~q_ptr_empty),
        .take     (take),
        .q_weight (q_weight),
        .gnt      (arb_gnt),
        .gnt_vld  (arb_vld)
    );

    always_comb begin
        ptr_in  = '0;
        byte_in = '0;
        for (int i = 0; i < NQ; i++) begin
            if (gnt_q == QW'(i)) begin
                ptr_in  = q_ptr_dout[i*PTR_W +: PTR_W];
                byte_in = q_data_dout[i*BYTE_W +: BYTE_W];
            end
        end
        len_in = ptr_in[LEN_W-1:0];
    end

    always_comb begin
        state_nxt  = state;
        take       = 1'b0;
        q_ptr_rd   = '0;
        q_data_rd  = '0;
        mac_ptr_wr = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable && arb_vld && !mac_ptr_full) begin
                    take      = 1'b1;
                    state_nxt = ST_PTR_RD;
                end
            end
            ST_PTR_RD: begin
                q_ptr_rd[gnt_q] = 1'b1;
                state_nxt       = ST_PTR_LAT;
            end
            ST_PTR_LAT: begin
                if (len_in == '0)
                    state_nxt = ST_IDLE;
                else if ({1'b0, len_in} > mac_data_free)
                    state_nxt = ST_WAIT_SPACE;
                else
                    state_nxt = ST_COPY;
            end
            ST_WAIT_SPACE: begin
                if ({1'b0, len_cnt} <= mac_data_free) state_nxt = ST_COPY;
            end
            ST_COPY: begin
                q_data_rd[gnt_q] = 1'b1;
                if (len_cnt == LEN_W'(1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  state_nxt = ST_PTR_WR;
            ST_PTR_WR: begin
                mac_ptr_wr = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // len_cnt is a down-counter ending at 1, so a full 2^LEN_W-1 frame never wraps.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            len_cnt    <= '0;
            rd_dly     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state  <= state_nxt;
            rd_dly <= (state == ST_COPY);
            if (take) gnt_q <= arb_gnt;
            if (state == ST_PTR_LAT) begin
                ptr_q   <= ptr_in;
                len_cnt <= len_in;
                if (len_in == '0 && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end else if (state == ST_COPY) begin
                len_cnt <= len_cnt - LEN_W'(1);
            end
        end
    end

    assign mac_data_wr  = rd_dly;
    assign mac_data_din = rd_dly ? byte_in : '0;
    assign mac_ptr_din  = mac_ptr_wr ? ptr_q : '0;
    assign busy         = (state != ST_IDLE);
    assign cur_q        = gnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_tx_queue_sched.sv
// Self-checking bench for tx_queue_sched: queue/MAC fifo models, byte/ptr scoreboard,
// a table of single-frame vectors and hand sequences for multi-cycle corners.
module tb_tx_queue_sched;

    localparam int NQ       = 4;
    localparam int LEN_W    = 12;
    localparam int WEIGHT_W = 4;
    localparam int DEPTH    = 64;
    localparam int DDEPTH   = 16384;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   enable;
    logic [NQ-1:0]          q_ptr_empty;
    logic [NQ-1:0]          q_ptr_rd;
    logic [NQ*16-1:0]       q_ptr_dout = '0;
    logic [NQ-1:0]          q_data_rd;
    logic [NQ*8-1:0]        q_data_dout = '0;
    logic [NQ*WEIGHT_W-1:0] q_weight;
    logic                   mac_ptr_full;
    logic                   mac_ptr_wr;
    logic [15:0]            mac_ptr_din;
    logic [LEN_W:0]         mac_data_free;
    logic                   mac_data_wr;
    logic [7:0]             mac_data_din;
    logic                   busy;
    logic [1:0]             cur_q;
    logic [15:0]            drop_cnt;

    always #5 clk = ~clk;

    tx_queue_sched #(.NQ(NQ), .LEN_W(LEN_W), .WEIGHT_W(WEIGHT_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .q_ptr_empty   (q_ptr_empty),
        .q_ptr_rd      (q_ptr_rd),
        .q_ptr_dout    (q_ptr_dout),
        .q_data_rd     (q_data_rd),
        .q_data_dout   (q_data_dout),
        .q_weight      (q_weight),
        .mac_ptr_full  (mac_ptr_full),
        .mac_ptr_wr    (mac_ptr_wr),
        .mac_ptr_din   (mac_ptr_din),
        .mac_data_free (mac_data_free),
        .mac_data_wr   (mac_data_wr),
        .mac_data_din  (mac_data_din),
        .busy          (busy),
        .cur_q         (cur_q),
        .drop_cnt      (drop_cnt)
    );

    // Per-queue source fifos with registered outputs.
    logic [15:0] pmem [NQ][DEPTH];
    logic [7:0]  dmem [NQ][DDEPTH];
    int pwr [NQ] = '{default: 0};
    int prd [NQ] = '{default: 0};
    int dwr [NQ] = '{default: 0};
    int drd [NQ] = '{default: 0};

    always_comb begin
        q_ptr_empty = '0;
        for (int i = 0; i < NQ; i++) q_ptr_empty[i] = (pwr[i] == prd[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (q_ptr_rd[i]) begin
                q_ptr_dout[i*16 +: 16] <= pmem[i][prd[i] % DEPTH];
                prd[i] <= prd[i] + 1;
            end
            if (q_data_rd[i]) begin
                q_data_dout[i*8 +: 8] <= dmem[i][drd[i] % DDEPTH];
                drd[i] <= drd[i] + 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc = 0, n_rd = 0, n_wr = 0, n_pwr = 0, n_busy = 0;
    int last_wr_cyc = -1, last_gap = -1;
    int grants[$];
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_ptrs[$];

    typedef struct {
        int q;
        int len;
        int free;
        int exp_busy;
        int exp_drop;
    } vec_t;
    vec_t vecs[5];

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] pat(input int q, input int k, input int j);
        return 8'(q*61 + k*29 + j*7 + 3);
    endfunction

    function automatic logic [15:0] mkptr(input int q, input int k, input int len);
        return {2'(q), 2'(k), 12'(len)};
    endfunction

    task automatic load_frame(input int q, input int k, input int len);
        for (int j = 0; j < len; j++) begin
            dmem[q][dwr[q] % DDEPTH] = pat(q, k, j);
            dwr[q]++;
        end
        pmem[q][pwr[q] % DEPTH] = mkptr(q, k, len);
        pwr[q]++;
    endtask

    task automatic push_exp(input int q, input int k, input int len);
        if (len != 0) begin
            for (int j = 0; j < len; j++) exp_bytes.push_back(pat(q, k, j));
            exp_ptrs.push_back(mkptr(q, k, len));
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_pwr = 0; n_busy = 0;
        grants.delete();
    endtask

    // One cycle: sample at the falling edge and run the scoreboard.
    task automatic tick();
        logic [7:0]  eb;
        logic [15:0] ep;
        @(negedge clk);
        cyc++;
        if (busy) n_busy++;
        if (|q_data_rd) n_rd++;
        for (int i = 0; i < NQ; i++) begin
            if (q_ptr_rd[i]) begin
                grants.push_back(i);
                if (last_wr_cyc >= 0) last_gap = cyc - last_wr_cyc;
            end
        end
        if (mac_data_wr) begin
            n_wr++;
            chk("sb_byte_expected", exp_bytes.size() > 0, 1);
            if (exp_bytes.size() > 0) begin
                eb = exp_bytes.pop_front();
                chk("sb_byte", mac_data_din, eb);
            end
        end
        if (mac_ptr_wr) begin
            n_pwr++;
            last_wr_cyc = cyc;
            chk("sb_ptr_expected", exp_ptrs.size() > 0, 1);
            if (exp_ptrs.size() > 0) begin
                ep = exp_ptrs.pop_front();
                chk("sb_ptr", mac_ptr_din, ep);
            end
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(!busy && (&q_ptr_empty)) && k < budget);
        chk({name, "_done"}, (!busy && (&q_ptr_empty)), 1);
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        repeat (n) tick();
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drop0;
        int kc[NQ];
        int exp_g[12];
        rstn          = 1'b0;
        enable        = 1'b0;
        mac_ptr_full  = 1'b0;
        mac_data_free = 13'd4095;
        q_weight      = {4'd1, 4'd1, 4'd1, 4'd3};

        vecs[0] = '{2, 64,   4095, 68,   0};
        vecs[1] = '{0, 1,    4095, 5,    0};
        vecs[2] = '{3, 0,    0,    2,    1};
        vecs[3] = '{1, 4095, 4095, 4099, 0};
        vecs[4] = '{1, 2,    2,    6,    0};

        do_reset(3);
        chk("rst_busy", busy, 0);
        chk("rst_cur_q", cur_q, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_strobes", {q_ptr_rd, q_data_rd, mac_ptr_wr, mac_data_wr}, 0);
        chk("rst_din", {mac_ptr_din, mac_data_din}, 0);

        enable = 1'b1;
        for (int r = 0; r < 5; r++) begin
            clear_stats();
            drop0 = drop_cnt;
            mac_data_free = 13'(vecs[r].free);
            load_frame(vecs[r].q, r % 4, vecs[r].len);
            push_exp(vecs[r].q, r % 4, vecs[r].len);
            wait_done(6000, "vec");
            chk("vec_grant", (grants.size() == 1) ? grants[0] : -1, vecs[r].q);
            chk("vec_data_rd", n_rd, vecs[r].len);
            chk("vec_mac_wr", n_wr, vecs[r].len);
            chk("vec_ptr_wr", n_pwr, (vecs[r].len != 0) ? 1 : 0);
            chk("vec_busy_cycles", n_busy, vecs[r].exp_busy);
            chk("vec_drop_cnt", drop_cnt, drop0 + vecs[r].exp_drop);
            chk("vec_cur_q", cur_q, vecs[r].q);
        end

        // Back-to-back frames from Q2: one idle cycle between ptr write and next ptr read.
        mac_data_free = 13'd4095;
        enable = 1'b0;
        load_frame(2, 0, 64);
        load_frame(2, 1, 64);
        push_exp(2, 0, 64);
        push_exp(2, 1, 64);
        clear_stats();
        enable = 1'b1;
        wait_done(400, "b2b");
        chk("b2b_grants", grants.size(), 2);
        chk("b2b_ptr_wr", n_pwr, 2);
        chk("b2b_gap", last_gap, 2);

        // Grant order with every queue holding 3 frames.
        enable = 1'b0;
        do_reset(2);
`ifdef TX_SCHED_WRR_EN
        exp_g = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 1, 2, 3};
`else
        exp_g = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`endif
        for (int q = 0; q < NQ; q++) begin
            kc[q] = 0;
            for (int k = 0; k < 3; k++) load_frame(q, k, 3 + q + k);
        end
        for (int n = 0; n < 12; n++) begin
            push_exp(exp_g[n], kc[exp_g[n]], 3 + exp_g[n] + kc[exp_g[n]]);
            kc[exp_g[n]]++;
        end
        clear_stats();
        enable = 1'b1;
        wait_done(500, "order");
        chk("order_count", grants.size(), 12);
        for (int n = 0; n < 12; n++)
            chk($sformatf("order_grant%0d", n), (n < grants.size()) ? grants[n] : -1, exp_g[n]);

        // Frame larger than MAC free space waits without reading.
        clear_stats();
        mac_data_free = 13'd1000;
        load_frame(1, 3, 1500);
        push_exp(1, 3, 1500);
        repeat (20) tick();
        chk("wait_busy", busy, 1);
        chk("wait_no_reads", n_rd, 0);
        mac_data_free = 13'd1500;
        tick();
        chk("wait_copy_start", q_data_rd, 4'b0010);
        wait_done(2000, "wait");
        chk("wait_mac_wr", n_wr, 1500);
        chk("wait_ptr_wr", n_pwr, 1);

        // MAC ptr fifo full blocks the grant.
        clear_stats();
        mac_ptr_full = 1'b1;
        load_frame(1, 2, 4);
        push_exp(1, 2, 4);
        repeat (6) tick();
        chk("ptrfull_no_grant", n_busy, 0);
        mac_ptr_full = 1'b0;
        wait_done(50, "ptrfull");
        chk("ptrfull_ptr_wr", n_pwr, 1);

        // Enable drop mid-frame: the frame finishes, the next one waits.
        clear_stats();
        load_frame(3, 0, 10);
        load_frame(3, 1, 10);
        push_exp(3, 0, 10);
        push_exp(3, 1, 10);
        for (int k = 0; k < 20 && n_rd == 0; k++) tick();
        enable = 1'b0;
        repeat (40) tick();
        chk("endrop_ptr_wr", n_pwr, 1);
        chk("endrop_idle", busy, 0);
        chk("endrop_pending", q_ptr_empty[3], 0);
        enable = 1'b1;
        wait_done(50, "endrop");
        chk("endrop_ptr_wr2", n_pwr, 2);

        // Reset in the middle of a 200-byte copy.
        clear_stats();
        load_frame(0, 3, 200);
        push_exp(0, 3, 200);
        for (int k = 0; k < 100 && n_rd < 50; k++) tick();
        chk("rstmid_in_copy", n_rd >= 50, 1);
        rstn = 1'b0;
        tick();
        chk("rstmid_outputs",
            {q_ptr_rd, q_data_rd, mac_ptr_wr, mac_data_wr, mac_ptr_din, mac_data_din, busy, cur_q}, 0);
        chk("rstmid_drop_cnt", drop_cnt, 0);
        exp_bytes.delete();
        exp_ptrs.delete();
        for (int i = 0; i < NQ; i++) begin
            pwr[i] = prd[i];
            dwr[i] = drd[i];
        end
        tick();
        rstn = 1'b1;
        clear_stats();
        load_frame(0, 0, 20);
        push_exp(0, 0, 20);
        wait_done(100, "rstmid");
        chk("rstmid_mac_wr", n_wr, 20);
        chk("rstmid_ptr_wr", n_pwr, 1);
        chk("rstmid_grant", (grants.size() == 1) ? grants[0] : -1, 0);

        chk("sb_bytes_left", exp_bytes.size(), 0);
        chk("sb_ptrs_left", exp_ptrs.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
